// File: rtl/lfsr_checker_if.sv
// Symbol stream and status bundle between an LFSR source and lfsr_checker.
// The counter width must match the checker's CNT_W parameter.
interface lfsr_checker_if #(
  parameter int CNT_W = 16
);
  logic             i_valid;
  logic [3:0]       i_data;
  logic             i_clear;
  logic             o_locked;
  logic             o_err;
  logic [CNT_W-1:0] o_err_cnt;
  logic [CNT_W-1:0] o_sym_cnt;

  modport master (
    output i_valid, i_data, i_clear,
    input  o_locked, o_err, o_err_cnt, o_sym_cnt
  );

  modport slave (
    input  i_valid, i_data, i_clear,
    output o_locked, o_err, o_err_cnt, o_sym_cnt
  );
endinterface

// File: rtl/lfsr_checker.sv
// Locks onto a 4-bit maximal-length LFSR symbol stream, then free-runs its own
// copy and counts mismatches and checked symbols until lock is lost.
module lfsr_checker #(
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3,
  parameter int CNT_W    = 16
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  lfsr_checker_if.slave  bus
);
  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

  localparam logic [3:0]       LOCK_TGT = 4'(LOCK_CNT);
  localparam logic [3:0]       LOSS_TGT = 4'(LOSS_CNT);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  function automatic logic [3:0] next_sym(input logic [3:0] s);
    return {s[2:0], s[3] ^ s[0]};
  endfunction

  state_t           state;
  logic [3:0]       exp_sym;
  logic [3:0]       run;
  logic [3:0]       miss;
  logic             locked;
  logic             err;
  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0] sym_cnt;

  logic [3:0] data;
  logic       match;
  logic [3:0] run_inc;
  logic [3:0] miss_inc;

  assign data     = bus.i_data;
  assign match    = (data == exp_sym);
  assign run_inc  = run + 4'd1;
  assign miss_inc = miss + 4'd1;

  // Zero never equals exp_sym in VERIFY/LOCKED, so it always lands on the mismatch paths.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= SEARCH;
      exp_sym <= 4'd0;
      run     <= 4'd0;
      miss    <= 4'd0;
      locked  <= 1'b0;
      err     <= 1'b0;
      err_cnt <= '0;
      sym_cnt <= '0;
    end else begin
      err <= 1'b0;
      if (bus.i_valid) begin
        unique case (state)
          SEARCH: begin
            if (data != 4'd0) begin
              exp_sym <= next_sym(data);
              run     <= 4'd1;
              state   <= VERIFY;
            end
          end
          VERIFY: begin
            if (match) begin
              exp_sym <= next_sym(data);
              run     <= run_inc;
              if (run_inc == LOCK_TGT) begin
                state  <= LOCKED;
                locked <= 1'b1;
                miss   <= 4'd0;
              end
            end else if (data != 4'd0) begin
              exp_sym <= next_sym(data);
              run     <= 4'd1;
            end else begin
              state <= SEARCH;
            end
          end
          LOCKED: begin
            exp_sym <= next_sym(exp_sym);
            if (sym_cnt != CNT_MAX) sym_cnt <= sym_cnt + 1'b1;
            if (match) begin
              miss <= 4'd0;
            end else begin
              err  <= 1'b1;
              miss <= miss_inc;
              if (err_cnt != CNT_MAX) err_cnt <= err_cnt + 1'b1;
              if (miss_inc == LOSS_TGT) begin
                state  <= SEARCH;
                locked <= 1'b0;
              end
            end
          end
          default: state <= SEARCH;
        endcase
      end
      // Placed last so a clear overrides any increment from the same symbol.
      if (bus.i_clear) begin
        err_cnt <= '0;
        sym_cnt <= '0;
      end
    end
  end

  assign bus.o_locked  = locked;
  assign bus.o_err     = err;
  assign bus.o_err_cnt = err_cnt;
  assign bus.o_sym_cnt = sym_cnt;
endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker: expected outputs are queued as each symbol
// is driven and compared one cycle later when the checker responds.
module tb_lfsr_checker;
  localparam int CNT_W = 4;
  localparam int SAT   = 15;

  logic clk;
  logic rst_n;

  lfsr_checker_if #(.CNT_W(CNT_W)) bus ();

  lfsr_checker #(.LOCK_CNT(4), .LOSS_CNT(3), .CNT_W(CNT_W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int locked;
    int err;
    int ecnt;
    int scnt;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int step_no = 0;

  // Reference sequence from seed 0001, written out rather than computed.
  int seq[15] = '{1, 3, 7, 15, 14, 13, 10, 5, 11, 6, 12, 9, 2, 4, 8};

  function automatic int sat(input int v);
    return (v > SAT) ? SAT : v;
  endfunction

  task automatic check_field(input string tag, input logic [31:0] obs, input logic [31:0] expd);
    checks++;
    assert (obs === expd) else begin
      errors++;
      $error("[TB] FAIL step %0d %s: observed %0d expected %0d", step_no, tag, obs, expd);
    end
  endtask

  task automatic check_output();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("[TB] FAIL step %0d scoreboard: observed empty queue expected an entry", step_no);
    end else begin
      e = sb.pop_front();
      check_field("o_locked",  32'(bus.o_locked),  32'(e.locked));
      check_field("o_err",     32'(bus.o_err),     32'(e.err));
      check_field("o_err_cnt", 32'(bus.o_err_cnt), 32'(e.ecnt));
      check_field("o_sym_cnt", 32'(bus.o_sym_cnt), 32'(e.scnt));
    end
  endtask

  // Drive one cycle of input away from the active edge, then check just after it.
  task automatic apply_stimulus(input logic v, input logic [3:0] d, input logic c,
                                input int locked, input int err, input int ecnt, input int scnt);
    @(negedge clk);
    step_no++;
    bus.i_valid = v;
    bus.i_data  = d;
    bus.i_clear = c;
    sb.push_back('{locked, err, ecnt, scnt});
    @(posedge clk);
    #1;
    check_output();
  endtask

  initial begin
    int idx;
    int ecnt;
    int scnt;

    bus.i_valid = 1'b0;
    bus.i_data  = 4'd0;
    bus.i_clear = 1'b0;
    rst_n       = 1'b0;

    #12;
    sb.push_back('{0, 0, 0, 0});
    check_output();
    @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset: nothing moves, lock never appears.
    for (int i = 0; i < 20; i++) apply_stimulus(1'b0, 4'hF, 1'b0, 0, 0, 0, 0);

    // Acquire lock on 1,3,7,15, then two checked symbols.
    apply_stimulus(1'b1, 4'd1,  1'b0, 0, 0, 0, 0);
    apply_stimulus(1'b1, 4'd3,  1'b0, 0, 0, 0, 0);
    apply_stimulus(1'b1, 4'd7,  1'b0, 0, 0, 0, 0);
    apply_stimulus(1'b1, 4'd15, 1'b0, 1, 0, 0, 0);
    apply_stimulus(1'b1, 4'd14, 1'b0, 1, 0, 0, 1);
    apply_stimulus(1'b1, 4'd13, 1'b0, 1, 0, 0, 2);

    // Expected 10: a zero is one error, then 5 matches the free-running copy.
    apply_stimulus(1'b1, 4'd0,  1'b0, 1, 1, 1, 3);
    apply_stimulus(1'b1, 4'd5,  1'b0, 1, 0, 1, 4);

    // Idle gaps between sequence symbols change nothing.
    apply_stimulus(1'b1, 4'd11, 1'b0, 1, 0, 1, 5);
    apply_stimulus(1'b0, 4'hF,  1'b0, 1, 0, 1, 5);
    apply_stimulus(1'b0, 4'h0,  1'b0, 1, 0, 1, 5);
    apply_stimulus(1'b1, 4'd6,  1'b0, 1, 0, 1, 6);
    apply_stimulus(1'b0, 4'hF,  1'b0, 1, 0, 1, 6);
    apply_stimulus(1'b1, 4'd12, 1'b0, 1, 0, 1, 7);
    for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 4'hF, 1'b0, 1, 0, 1, 7);
    apply_stimulus(1'b1, 4'd9,  1'b0, 1, 0, 1, 8);

    // Clear with a mismatch: the pulse still fires but both counters read zero.
    apply_stimulus(1'b1, 4'd7,  1'b1, 1, 1, 0, 0);
    apply_stimulus(1'b1, 4'd4,  1'b0, 1, 0, 0, 1);

    // Three consecutive misses drop lock; counters survive the loss.
    apply_stimulus(1'b1, 4'd0,  1'b0, 1, 1, 1, 2);
    apply_stimulus(1'b1, 4'd0,  1'b0, 1, 1, 2, 3);
    apply_stimulus(1'b1, 4'd0,  1'b0, 0, 1, 3, 4);
    apply_stimulus(1'b0, 4'd0,  1'b0, 0, 0, 3, 4);

    // Relock on 5,11,6,12 and drive both counters into saturation.
    apply_stimulus(1'b1, 4'd5,  1'b0, 0, 0, 3, 4);
    apply_stimulus(1'b1, 4'd11, 1'b0, 0, 0, 3, 4);
    apply_stimulus(1'b1, 4'd6,  1'b0, 0, 0, 3, 4);
    apply_stimulus(1'b1, 4'd12, 1'b0, 1, 0, 3, 4);
    idx  = 11;
    ecnt = 3;
    scnt = 4;
    for (int k = 0; k < 13; k++) begin
      ecnt = sat(ecnt + 1);
      scnt = sat(scnt + 1);
      apply_stimulus(1'b1, 4'd0, 1'b0, 1, 1, ecnt, scnt);
      idx  = (idx + 1) % 15;
      scnt = sat(scnt + 1);
      apply_stimulus(1'b1, 4'(seq[idx]), 1'b0, 1, 0, ecnt, scnt);
      idx  = (idx + 1) % 15;
    end

    // Reset mid-lock clears everything without waiting for a clock edge.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    step_no++;
    sb.push_back('{0, 0, 0, 0});
    check_output();
    @(negedge clk);
    rst_n = 1'b1;

    // Relock only through SEARCH/VERIFY: zero aborts, a wrong symbol reseeds.
    apply_stimulus(1'b1, 4'd1,  1'b0, 0, 0, 0, 0);
    apply_stimulus(1'b1, 4'd3,  1'b0, 0, 0, 0, 0);
    apply_stimulus(1'b1, 4'd0,  1'b0, 0, 0, 0, 0);
    apply_stimulus(1'b1, 4'd7,  1'b0, 0, 0, 0, 0);
    apply_stimulus(1'b1, 4'd15, 1'b0, 0, 0, 0, 0);
    apply_stimulus(1'b1, 4'd5,  1'b0, 0, 0, 0, 0);
    apply_stimulus(1'b1, 4'd11, 1'b0, 0, 0, 0, 0);
    apply_stimulus(1'b1, 4'd6,  1'b0, 0, 0, 0, 0);
    apply_stimulus(1'b1, 4'd12, 1'b0, 1, 0, 0, 0);
    apply_stimulus(1'b1, 4'd9,  1'b0, 1, 0, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
